// File: rtl/alu_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle controller and the ALU it drives.
// Holds ALU operation codes, opcode/funct constants and state encodings.
package alu_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_NOR  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1010
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EX   = 4'd10,
    S_IMM_WB   = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_e;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

endpackage

// File: rtl/alu_funct_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags
// unknown funct codes. Purely combinational.
module alu_funct_dec
  import alu_ctrl_fsm_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       illegal
);

  // Table lookup; unknown codes fall back to ADD and raise illegal.
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_XOR:  alu_op = ALU_XOR;
      FN_NOR:  alu_op = ALU_NOR;
      FN_SLT:  alu_op = ALU_SLT;
      FN_SLTU: alu_op = ALU_SLTU;
      FN_SLL:  alu_op = ALU_SLL;
      FN_SRL:  alu_op = ALU_SRL;
      FN_SRA:  alu_op = ALU_SRA;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multicycle MIPS-style control FSM. Outputs are decoded from the
// registered state; only alu_op/illegal in RTYPE_EX also look at funct.
// Optional feature macro: ALU_IMM_LOGIC_EN (andi/ori/xori with zero-extended
// immediates). When undefined those opcodes are illegal and imm_zext is 0.
module alu_ctrl_fsm
  import alu_ctrl_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       imm_zext,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [3:0] fn_alu_op;
  logic       fn_illegal;

`ifdef ALU_IMM_LOGIC_EN
  // ALU op and extension mode for IMM_EX, captured in DECODE so the
  // IMM_EX outputs depend on registered state only.
  logic [3:0] imm_op_q, imm_op_d;
  logic       imm_zext_q, imm_zext_d;
`endif

  alu_funct_dec u_funct_dec (
    .funct   (funct),
    .alu_op  (fn_alu_op),
    .illegal (fn_illegal)
  );

  // Next-state selection from the current state and the held instruction fields.
  always_comb begin
    state_d = S_FETCH;
`ifdef ALU_IMM_LOGIC_EN
    imm_op_d   = imm_op_q;
    imm_zext_d = imm_zext_q;
`endif
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI: begin
            state_d = S_IMM_EX;
`ifdef ALU_IMM_LOGIC_EN
            imm_op_d   = ALU_ADD;
            imm_zext_d = 1'b0;
`endif
          end
`ifdef ALU_IMM_LOGIC_EN
          OP_ANDI: begin
            state_d    = S_IMM_EX;
            imm_op_d   = ALU_AND;
            imm_zext_d = 1'b1;
          end
          OP_ORI: begin
            state_d    = S_IMM_EX;
            imm_op_d   = ALU_OR;
            imm_zext_d = 1'b1;
          end
          OP_XORI: begin
            state_d    = S_IMM_EX;
            imm_op_d   = ALU_XOR;
            imm_zext_d = 1'b1;
          end
`endif
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_RTYPE_EX: state_d = fn_illegal ? S_FETCH : S_ALU_WB;
      S_IMM_EX:   state_d = S_IMM_WB;
      // Final states of each instruction and unreachable codes return to FETCH.
      default:    state_d = S_FETCH;
    endcase
  end

  // State register; reset aborts any instruction back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
`ifdef ALU_IMM_LOGIC_EN
    imm_op_q   <= imm_op_d;
    imm_zext_q <= imm_zext_d;
`endif
  end

  // Moore output decode; everything is held inactive while reset is asserted.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_op        = ALU_ADD;
    imm_zext      = 1'b0;
    illegal       = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          alu_src_b = 2'b01;
          pc_write  = 1'b1;
        end
        S_DECODE:   alu_src_b = 2'b11;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_RTYPE_EX: begin
          alu_src_a = 1'b1;
          alu_op    = fn_alu_op;
          illegal   = fn_illegal;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_src        = 2'b01;
          pc_write_cond = 1'b1;
        end
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        S_IMM_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
`ifdef ALU_IMM_LOGIC_EN
          alu_op    = imm_op_q;
          imm_zext  = imm_zext_q;
`endif
        end
        S_IMM_WB:  reg_write = 1'b1;
        S_ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: random instruction stream with
// occasional mid-instruction resets, compared cycle by cycle against a
// per-instruction expected output sequence.
module tb_alu_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, imm_zext, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_op, state;

  alu_ctrl_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .alu_op        (alu_op),
    .imm_zext      (imm_zext),
    .illegal       (illegal),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bundle: [23:14] single-bit controls, [13:12] alu_src_b,
  // [11:10] pc_src, [9:6] alu_op, [5] imm_zext, [4] illegal, [3:0] state.
  logic [23:0] obs;
  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
                alu_op, imm_zext, illegal, state};

  localparam logic [9:0] B_PCW  = 10'b1000000000;
  localparam logic [9:0] B_PCWC = 10'b0100000000;
  localparam logic [9:0] B_IORD = 10'b0010000000;
  localparam logic [9:0] B_MR   = 10'b0001000000;
  localparam logic [9:0] B_MW   = 10'b0000100000;
  localparam logic [9:0] B_IRW  = 10'b0000010000;
  localparam logic [9:0] B_RW   = 10'b0000001000;
  localparam logic [9:0] B_RD   = 10'b0000000100;
  localparam logic [9:0] B_M2R  = 10'b0000000010;
  localparam logic [9:0] B_SA   = 10'b0000000001;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ctl(input int st, input logic [9:0] b,
                                      input logic [1:0] sb, input logic [1:0] ps,
                                      input logic [3:0] aop, input logic zx,
                                      input logic ill);
    logic [3:0] s4;
    s4 = st[3:0];
    return {b, sb, ps, aop, zx, ill, s4};
  endfunction

  // R-type funct table; returns 1 for a known funct.
  function automatic bit rtype_op(input logic [5:0] fn, output logic [3:0] op);
    op = 4'd0;
    case (fn)
      6'b100000: op = 4'd0;
      6'b100010: op = 4'd1;
      6'b101010: op = 4'd2;
      6'b101011: op = 4'd3;
      6'b100100: op = 4'd4;
      6'b100101: op = 4'd5;
      6'b100110: op = 4'd6;
      6'b100111: op = 4'd7;
      6'b000000: op = 4'd8;
      6'b000010: op = 4'd9;
      6'b000011: op = 4'd10;
      default:   return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Expected per-cycle outputs for one whole instruction, FETCH first.
  logic [23:0] exp_q[$];

  function automatic void build_seq(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] aop;
    exp_q.delete();
    exp_q.push_back(ctl(0, B_PCW | B_MR | B_IRW, 2'b01, 2'b00, 4'd0, 1'b0, 1'b0));
    exp_q.push_back(ctl(1, 10'd0, 2'b11, 2'b00, 4'd0, 1'b0, 1'b0));
    if (op == 6'b100011 || op == 6'b101011) begin
      exp_q.push_back(ctl(2, B_SA, 2'b10, 2'b00, 4'd0, 1'b0, 1'b0));
      if (op == 6'b100011) begin
        exp_q.push_back(ctl(3, B_IORD | B_MR, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0));
        exp_q.push_back(ctl(4, B_RW | B_M2R, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0));
      end else begin
        exp_q.push_back(ctl(5, B_IORD | B_MW, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0));
      end
    end else if (op == 6'b000000) begin
      if (rtype_op(fn, aop)) begin
        exp_q.push_back(ctl(6, B_SA, 2'b00, 2'b00, aop, 1'b0, 1'b0));
        exp_q.push_back(ctl(7, B_RW | B_RD, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0));
      end else begin
        exp_q.push_back(ctl(6, B_SA, 2'b00, 2'b00, 4'd0, 1'b0, 1'b1));
      end
    end else if (op == 6'b000100) begin
      exp_q.push_back(ctl(8, B_SA | B_PCWC, 2'b00, 2'b01, 4'd1, 1'b0, 1'b0));
    end else if (op == 6'b000010) begin
      exp_q.push_back(ctl(9, B_PCW, 2'b00, 2'b10, 4'd0, 1'b0, 1'b0));
    end else if (op == 6'b001000) begin
      exp_q.push_back(ctl(10, B_SA, 2'b10, 2'b00, 4'd0, 1'b0, 1'b0));
      exp_q.push_back(ctl(11, B_RW, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0));
`ifdef ALU_IMM_LOGIC_EN
    end else if (op == 6'b001100 || op == 6'b001101 || op == 6'b001110) begin
      aop = (op == 6'b001100) ? 4'd4 : (op == 6'b001101) ? 4'd5 : 4'd6;
      exp_q.push_back(ctl(10, B_SA, 2'b10, 2'b00, aop, 1'b1, 1'b0));
      exp_q.push_back(ctl(11, B_RW, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0));
`endif
    end else begin
      exp_q.push_back(ctl(12, 10'd0, 2'b00, 2'b00, 4'd0, 1'b0, 1'b1));
    end
  endfunction

  // Runs one instruction. abort_at: -1 none, -2 random cycle, >=0 that cycle;
  // reset is then held for 'hold' cycles and the instruction is abandoned.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int abort_at, input int hold);
    int at;
    build_seq(op, fn);
    at = abort_at;
    if (abort_at == -2) at = $urandom_range(0, exp_q.size() - 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      opcode = op;
      funct  = fn;
      if (i == at) begin
        reset = 1'b1;
        #1;
        chk($sformatf("op%02h c%0d reset-ctl", op, i), {obs[23:4], 4'h0}, 24'h0);
        for (int h = 1; h < hold; h++) begin
          @(posedge clk); #1;
          reset = 1'b1;
          #1;
          chk($sformatf("op%02h reset-hold%0d", op, h), obs, 24'h0);
        end
        return;
      end
      reset = 1'b0;
      #1;
      chk($sformatf("op%02h fn%02h c%0d", op, fn, i), obs, exp_q[i]);
    end
  endtask

  logic [5:0] legal_fn [11];
  logic [5:0] op_r, fn_r;
  int         ab;

  initial begin
    legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                 6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011};
    reset  = 1'b1;
    opcode = 6'd0;
    funct  = 6'd0;

    // Power-up reset: strobes inactive, state settles to FETCH.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      if (c == 0) chk("init reset-ctl", {obs[23:4], 4'h0}, 24'h0);
      else        chk("init reset", obs, 24'h0);
    end

    // Directed instructions.
    run_instr(6'b100011, 6'd0,      -1, 1);  // lw
    run_instr(6'b101011, 6'd0,      -1, 1);  // sw
    run_instr(6'b000000, 6'b100111, -1, 1);  // nor
    run_instr(6'b000000, 6'b111111, -1, 1);  // illegal funct
    run_instr(6'b000100, 6'd0,      -1, 1);  // beq
    run_instr(6'b000010, 6'd0,      -1, 1);  // j
    run_instr(6'b001000, 6'd0,      -1, 1);  // addi
    run_instr(6'b001101, 6'd0,      -1, 1);  // ori
    run_instr(6'b111111, 6'd0,      -1, 1);  // unknown opcode
    run_instr(6'b100011, 6'd0,       3, 1);  // lw aborted in MEMRD
    run_instr(6'b100011, 6'd0,      -1, 1);  // lw after abort
    run_instr(6'b000000, 6'b100000,  1, 3);  // add aborted in DECODE, long reset

    // Random instruction stream.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       op_r = 6'b100011;
        1:       op_r = 6'b101011;
        2, 3:    op_r = 6'b000000;
        4:       op_r = 6'b000100;
        5:       op_r = 6'b000010;
        6:       op_r = 6'b001000;
        7:       op_r = 6'b001100 + 6'($urandom_range(0, 2));
        default: op_r = 6'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0) fn_r = legal_fn[$urandom_range(0, 10)];
      else                           fn_r = 6'($urandom);
      ab = ($urandom_range(0, 7) == 0) ? -2 : -1;
      run_instr(op_r, fn_r, ab, $urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
